rom_fetch_sequencer: RTL and testbench

- Initiator side of the 32-bit read-only memory interface. The memory responds combinationally: it takes address[27:0] and readEn and drives data[31:0] in the same cycle.
- The block generates sequential word addresses, drives readEn, and captures returned words into a 2-entry buffer.
- Buffered words are handed downstream over a valid/ready handshake, each tagged with its address.
- Sits between the instruction/data ROM and the consumer (decode stage or test harness). Supports start, redirect, stop and end-of-memory termination.

---
 rtl/rom_fetch_sequencer.sv | 108 ++++++++++
 tb/tb_rom_fetch_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_sequencer.sv
// Initiator for a combinational-response ROM: fetches sequential words into a
// 2-entry buffer and hands them downstream with their addresses over valid/ready.
module rom_fetch_sequencer #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int LAST_ADDR  = 127,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirectAddr,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memReadEn,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  instrValid,
  input  logic                  instrReady,
  output logic [DATA_WIDTH-1:0] instrData,
  output logic [ADDR_WIDTH-1:0] instrAddr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [1:0]            DEPTH = 2'(BUF_DEPTH);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            count;
  logic [ADDR_WIDTH-1:0] entry_addr [2];
  logic [DATA_WIDTH-1:0] entry_data [2];
  logic                  done_q;
  logic                  flush, push, pop, finish;

  always_comb begin
    flush      = redirect && (state != IDLE);
    memReadEn  = (state == FETCH) && (count < DEPTH);
    memAddress = (state == FETCH) ? pc : '0;
    push       = memReadEn && !flush;
    pop        = (count != '0) && instrReady && !flush;
    finish     = (state == DRAIN) && !flush && (count == '0);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (flush) state_next = FETCH;
               else if (stop || (push && pc >= LAST)) state_next = DRAIN;
      DRAIN:   if (flush) state_next = FETCH;
               else if (count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      count      <= '0;
      done_q     <= 1'b0;
      entry_addr <= '{default: '0};
      entry_data <= '{default: '0};
    end else begin
      done_q <= finish;
      if (state == IDLE && start) begin
        pc <= startAddr;
      end else if (flush) begin
        pc    <= redirectAddr;
        count <= '0;
      end else begin
        if (push) pc <= pc + ADDR_WIDTH'(1);
        // Buffer is a 2-deep shift queue with the head always in entry 0;
        // push+pop together can only happen with exactly one entry held.
        case ({push, pop})
          2'b10: begin
            entry_addr[count[0]] <= pc;
            entry_data[count[0]] <= memData;
            count                <= count + 2'd1;
          end
          2'b01: begin
            entry_addr[0] <= entry_addr[1];
            entry_data[0] <= entry_data[1];
            count         <= count - 2'd1;
          end
          2'b11: begin
            entry_addr[0] <= pc;
            entry_data[0] <= memData;
          end
          default: ;
        endcase
      end
    end
  end

  assign instrValid = (count != '0);
  assign instrData  = instrValid ? entry_data[0] : '0;
  assign instrAddr  = instrValid ? entry_addr[0] : '0;
  assign busy       = (state != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: queue-based reference model checked every cycle,
// plus end-to-end delivered-sequence checks for directed and random runs.
module tb_rom_fetch_sequencer;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int LAST = 127;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, redirect = 1'b0, stop = 1'b0, instrReady = 1'b0;
  logic [AW-1:0] startAddr = '0, redirectAddr = '0;
  logic [AW-1:0] memAddress, instrAddr;
  logic          memReadEn, instrValid, busy, done;
  logic [DW-1:0] memData, instrData;
  logic [DW-1:0] key = '0;

  int n_vec = 0;
  int n_err = 0;

  rom_fetch_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LAST_ADDR (LAST),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .startAddr   (startAddr),
    .redirect    (redirect),
    .redirectAddr(redirectAddr),
    .stop        (stop),
    .memAddress  (memAddress),
    .memReadEn   (memReadEn),
    .memData     (memData),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .instrData   (instrData),
    .instrAddr   (instrAddr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Memory: word content is its address XOR a per-run key.
  always_comb memData = memReadEn ? (DW'(memAddress) ^ key) : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words held in the output buffer, as addresses.
  bit            m_active = 1'b0, m_fetch = 1'b0, m_done = 1'b0;
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] q[$];
  logic [AW-1:0] deliv[$];
  int            deliv_cyc[$];
  int            cyc = 0;
  int            done_seen = 0;
  int            reads_seen = 0;

  always @(negedge clk) begin
    bit rd, pp, fin;
    cyc++;
    check_eq("busy", busy, m_active);
    check_eq("done", done, m_done);
    check_eq("memReadEn", memReadEn, m_fetch && q.size() < 2);
    if (m_fetch && q.size() < 2) check_eq("memAddress", memAddress, m_pc);
    check_eq("instrValid", instrValid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("instrAddr", instrAddr, q[0]);
      check_eq("instrData", instrData, DW'(q[0]) ^ key);
    end else begin
      check_eq("instrAddr empty", instrAddr, 0);
      check_eq("instrData empty", instrData, 0);
    end
    if (done) done_seen++;
    if (memReadEn) reads_seen++;
    if (!reset && instrValid && instrReady && !(redirect && busy)) begin
      deliv.push_back(instrAddr);
      deliv_cyc.push_back(cyc);
    end
    // advance the model across the coming rising edge
    if (reset) begin
      m_active = 0; m_fetch = 0; m_done = 0; m_pc = '0; q.delete();
    end else if (!m_active) begin
      m_done = 0;
      if (start) begin
        m_active = 1; m_fetch = 1; m_pc = startAddr;
      end
    end else if (redirect) begin
      q.delete(); m_pc = redirectAddr; m_fetch = 1; m_done = 0;
    end else begin
      rd  = m_fetch && q.size() < 2;
      pp  = q.size() != 0 && instrReady;
      fin = !m_fetch && q.size() == 0;
      m_done = fin;
      if (fin) m_active = 0;
      if (pp) void'(q.pop_front());
      if (rd) begin
        q.push_back(m_pc);
        if (m_pc >= AW'(LAST)) m_fetch = 0;
        m_pc = m_pc + AW'(1);
      end
      if (stop) m_fetch = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [AW-1:0] a);
    deliv.delete();
    deliv_cyc.delete();
    done_seen  = 0;
    reads_seen = 0;
    startAddr  = a;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int c = 0;
    while (done_seen == 0 && c < maxc) begin
      tick();
      c++;
    end
    check_eq({tag, " timeout"}, done_seen != 0, 1);
    tick(2);
    check_eq({tag, " done count"}, done_seen, 1);
    check_eq({tag, " busy after"}, busy, 0);
  endtask

  task automatic check_list(input string tag, input logic [AW-1:0] exp[$]);
    check_eq({tag, " length"}, deliv.size(), exp.size());
    for (int i = 0; i < exp.size() && i < deliv.size(); i++)
      check_eq({tag, " word"}, deliv[i], exp[i]);
  endtask

  task automatic check_seq(input string tag, input logic [AW-1:0] first, input int n);
    logic [AW-1:0] exp[$];
    for (int i = 0; i < n; i++) exp.push_back(first + AW'(i));
    check_list(tag, exp);
  endtask

  initial begin
    logic [AW-1:0] exp[$];
    logic [AW-1:0] a;
    int c;
    int nred;

    tick(2);
    reset = 1'b0;
    check_eq("reset memAddress", memAddress, 0);
    check_eq("reset memReadEn", memReadEn, 0);
    check_eq("reset instrValid", instrValid, 0);
    check_eq("reset busy", busy, 0);

    // full sweep, data = address, consumer always ready
    key = '0;
    instrReady = 1'b1;
    start_run('0);
    wait_done("sweep", 400);
    check_seq("sweep", '0, 128);
    if (deliv_cyc.size() == 128)
      check_eq("sweep throughput", deliv_cyc[127] - deliv_cyc[0], 127);

    // backpressure: stalled consumer for 5 cycles
    key = $urandom;
    instrReady = 1'b0;
    start_run('0);
    tick(4);
    check_eq("stall reads", reads_seen, 2);
    check_eq("stall head", instrData, key);
    instrReady = 1'b1;
    wait_done("backpressure", 400);
    check_seq("backpressure", '0, 128);

    // redirect to 100 while fetching address 10
    key = $urandom;
    start_run('0);
    c = 0;
    while (!(memReadEn && memAddress == AW'(10)) && c < 50) begin
      tick();
      c++;
    end
    check_eq("redirect reach pc10", memAddress, 10);
    redirect = 1'b1;
    redirectAddr = AW'(100);
    tick();
    redirect = 1'b0;
    wait_done("redirect", 400);
    exp.delete();
    for (int i = 0; i <= 8; i++) exp.push_back(AW'(i));
    for (int i = 100; i <= 127; i++) exp.push_back(AW'(i));
    check_list("redirect", exp);

    // early stop in the cycle address 8 is read
    key = $urandom;
    start_run(AW'(5));
    c = 0;
    while (!(memReadEn && memAddress == AW'(8)) && c < 50) begin
      tick();
      c++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("stop", 100);
    check_seq("stop", AW'(5), 4);

    // last address, with a second start while busy
    key = $urandom;
    instrReady = 1'b0;
    start_run(AW'(LAST));
    tick();
    startAddr = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    instrReady = 1'b1;
    wait_done("last", 100);
    check_seq("last", AW'(LAST), 1);

    // start beyond the last address: one word only
    a = AW'($urandom) | AW'(128);
    start_run(a);
    wait_done("beyond", 100);
    check_seq("beyond", a, 1);

    // reset with a full buffer
    instrReady = 1'b0;
    start_run(AW'(3));
    tick(3);
    check_eq("pre-reset valid", instrValid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid reset memAddress", memAddress, 0);
    check_eq("mid reset memReadEn", memReadEn, 0);
    check_eq("mid reset instrValid", instrValid, 0);
    check_eq("mid reset instrData", instrData, 0);
    check_eq("mid reset instrAddr", instrAddr, 0);
    check_eq("mid reset busy", busy, 0);
    check_eq("mid reset done", done, 0);
    done_seen = 0;
    tick(3);
    check_eq("mid reset no done", done_seen, 0);
    instrReady = 1'b1;
    start_run(AW'(3));
    wait_done("after reset", 400);
    check_seq("after reset", AW'(3), 125);

    // random runs: random backpressure, stops and redirects
    for (int r = 0; r < 20; r++) begin
      key = $urandom;
      start_run(AW'($urandom_range(0, LAST)));
      c = 0;
      nred = 0;
      while (done_seen == 0 && c < 2000) begin
        instrReady = ($urandom_range(0, 3) != 0);
        redirect   = (nred < 2) && ($urandom_range(0, 39) == 0);
        if (redirect) begin
          redirectAddr = AW'($urandom_range(0, LAST));
          nred++;
        end
        stop = ($urandom_range(0, 59) == 0);
        tick();
        c++;
      end
      redirect = 1'b0;
      stop = 1'b0;
      instrReady = 1'b1;
      check_eq("random timeout", done_seen != 0, 1);
      tick(2);
      check_eq("random done count", done_seen, 1);
      check_eq("random busy after", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
